// File: rtl/reg_bus_arbiter_if.sv
// Requester handshake and register-bus signals shared by the arbiter and its environment.
// The master modport is the arbiter's view; slave is the requester/register-file side.
interface reg_bus_arbiter_if #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_write;
    logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
    logic [NUM_REQ*DATA_BITS-1:0] req_wdata;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [DATA_BITS-1:0]         rsp_rdata;
    logic [ADDR_BITS-1:0]         bus_addr;
    logic [DATA_BITS-1:0]         bus_wdata;
    logic                         bus_w_en;
    logic                         bus_r_en;
    logic [DATA_BITS-1:0]         bus_rdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, bus_addr, bus_wdata, bus_w_en, bus_r_en
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, bus_addr, bus_wdata, bus_w_en, bus_r_en
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter for the LED-driver register bus: one strobe per accepted
// single-beat request, with a one-hot completion pulse back to the owning requester.
module reg_bus_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 8,
    parameter int RD_LATENCY = 1,
    localparam int IDX_BITS  = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sleep,
    reg_bus_arbiter_if.master   bus_if,
    output logic                busy,
    output logic [IDX_BITS-1:0] grant_id
);
    localparam int CNT_BITS = 3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    arb_state_e            state_q;
    logic [IDX_BITS-1:0]   last_ptr_q;
    logic [IDX_BITS-1:0]   grant_id_q;
    logic                  write_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [DATA_BITS-1:0]  wdata_q;
    logic [DATA_BITS-1:0]  rdata_q;
    logic                  w_en_q;
    logic                  r_en_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [CNT_BITS-1:0]   cnt_q;

    logic                  found;
    logic [IDX_BITS-1:0]   winner;
    int                    cand;
    logic [NUM_REQ-1:0]    ready;
    logic                  accept;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_ptr_q) + k) % NUM_REQ;
            if (!found && bus_if.req_valid[cand]) begin
                found  = 1'b1;
                winner = IDX_BITS'(cand);
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state_q == ARB_IDLE && !sleep && found) begin
            ready[winner] = 1'b1;
        end
    end

    assign accept = |(bus_if.req_valid & ready);

    // NOTE: all state, including the latched bus fields, clears asynchronously so an
    // aborted transaction leaves no strobe or response behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            last_ptr_q  <= IDX_BITS'(NUM_REQ - 1);
            grant_id_q  <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            w_en_q      <= 1'b0;
            r_en_q      <= 1'b0;
            rsp_valid_q <= '0;
            cnt_q       <= '0;
        end else begin
            w_en_q      <= 1'b0;
            r_en_q      <= 1'b0;
            rsp_valid_q <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (accept) begin
                        state_q    <= ARB_ISSUE;
                        grant_id_q <= winner;
                        last_ptr_q <= winner;
                        write_q    <= bus_if.req_write[winner];
                        addr_q     <= bus_if.req_addr[int'(winner)*ADDR_BITS +: ADDR_BITS];
                        wdata_q    <= bus_if.req_wdata[int'(winner)*DATA_BITS +: DATA_BITS];
                        w_en_q     <= bus_if.req_write[winner];
                        r_en_q     <= !bus_if.req_write[winner];
                    end
                end
                ARB_ISSUE: begin
                    if (write_q) begin
                        state_q     <= ARB_RESP;
                        rsp_valid_q <= NUM_REQ'(1) << grant_id_q;
                    end else begin
                        state_q <= ARB_WAIT;
                        cnt_q   <= CNT_BITS'(RD_LATENCY - 1);
                    end
                end
                ARB_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= ARB_RESP;
                        rdata_q     <= bus_if.bus_rdata;
                        rsp_valid_q <= NUM_REQ'(1) << grant_id_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ARB_RESP: state_q <= ARB_IDLE;
                default:  state_q <= ARB_IDLE;
            endcase
        end
    end

    assign bus_if.req_ready = ready;
    assign bus_if.rsp_valid = rsp_valid_q;
    assign bus_if.rsp_rdata = rdata_q;
    assign bus_if.bus_addr  = addr_q;
    assign bus_if.bus_wdata = wdata_q;
    assign bus_if.bus_w_en  = w_en_q;
    assign bus_if.bus_r_en  = r_en_q;
    assign busy             = (state_q != ARB_IDLE);
    assign grant_id         = grant_id_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter with RD_LATENCY=2 and a delayed-read register model.
module tb_reg_bus_arbiter;
    localparam int NR     = 3;
    localparam int AB     = 8;
    localparam int DB     = 8;
    localparam int RD_LAT = 2;

    logic       clk;
    logic       reset_n;
    logic       sleep;
    logic       busy;
    logic [1:0] grant_id;
    logic [1:0] rd_pipe;

    int tests_run = 0;
    int failed    = 0;

    reg_bus_arbiter_if #(.NUM_REQ(NR), .ADDR_BITS(AB), .DATA_BITS(DB)) bif ();

    reg_bus_arbiter #(
        .NUM_REQ(NR), .ADDR_BITS(AB), .DATA_BITS(DB), .RD_LATENCY(RD_LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sleep(sleep),
        .bus_if(bif.master), .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rd_model(input logic [7:0] a);
        return (a == 8'h10) ? 8'h3C : (a ^ 8'h5A);
    endfunction

    // Register file returns data exactly RD_LAT cycles after the read strobe, garbage otherwise.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_pipe <= '0;
        else          rd_pipe <= {rd_pipe[0], bif.bus_r_en};
    end
    assign bif.bus_rdata = rd_pipe[RD_LAT-1] ? rd_model(bif.bus_addr) : 8'hEE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sleep = 1'b0;
        bif.req_valid = '0; bif.req_write = '0; bif.req_addr = '0; bif.req_wdata = '0;
        #3;
        tests_run++; if ({busy, bif.bus_w_en, bif.bus_r_en, bif.rsp_valid, bif.req_ready} !== 9'h0) begin failed++; $display("FAIL rst_ctrl: got %b exp 0", {busy, bif.bus_w_en, bif.bus_r_en, bif.rsp_valid, bif.req_ready}); end
        tests_run++; if ({bif.bus_addr, bif.bus_wdata, bif.rsp_rdata} !== 24'h0) begin failed++; $display("FAIL rst_data: got %h exp 0", {bif.bus_addr, bif.bus_wdata, bif.rsp_rdata}); end
        tests_run++; if (grant_id !== 2'd0) begin failed++; $display("FAIL rst_grant: got %0d exp 0", grant_id); end
        @(posedge clk); @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic test_write();
        tick();
        bif.req_valid = 3'b001; bif.req_write = 3'b001;
        bif.req_addr = {8'h00, 8'h00, 8'h05}; bif.req_wdata = {8'h00, 8'h00, 8'hA5};
        #1;
        tests_run++; if (bif.req_ready !== 3'b001) begin failed++; $display("FAIL wr_ready: got %b exp 001", bif.req_ready); end
        tick();
        bif.req_valid = '0;
        tests_run++; if ({bif.bus_w_en, bif.bus_r_en} !== 2'b10) begin failed++; $display("FAIL wr_strobe: got %b exp 10", {bif.bus_w_en, bif.bus_r_en}); end
        tests_run++; if ({bif.bus_addr, bif.bus_wdata} !== 16'h05A5) begin failed++; $display("FAIL wr_bus: got %h exp 05a5", {bif.bus_addr, bif.bus_wdata}); end
        tests_run++; if ({busy, grant_id} !== 3'b100) begin failed++; $display("FAIL wr_busy: got %b exp 100", {busy, grant_id}); end
        tick();
        tests_run++; if (bif.rsp_valid !== 3'b001) begin failed++; $display("FAIL wr_rsp: got %b exp 001", bif.rsp_valid); end
        tests_run++; if ({bif.bus_w_en, bif.rsp_rdata} !== 9'h000) begin failed++; $display("FAIL wr_rdata: got %h exp 000", {bif.bus_w_en, bif.rsp_rdata}); end
        tick();
        tests_run++; if ({busy, bif.rsp_valid} !== 4'b0000) begin failed++; $display("FAIL wr_done: got %b exp 0000", {busy, bif.rsp_valid}); end
    endtask

    task automatic test_read();
        tick();
        bif.req_valid = 3'b010; bif.req_write = 3'b000;
        bif.req_addr = {8'h00, 8'h10, 8'h00};
        #1;
        tests_run++; if (bif.req_ready !== 3'b010) begin failed++; $display("FAIL rd_ready: got %b exp 010", bif.req_ready); end
        tick();
        bif.req_valid = '0;
        tests_run++; if ({bif.bus_r_en, bif.bus_w_en, bif.bus_addr} !== 10'b10_0001_0000) begin failed++; $display("FAIL rd_strobe: got %b exp 1000010000", {bif.bus_r_en, bif.bus_w_en, bif.bus_addr}); end
        tick();
        tests_run++; if ({bif.bus_r_en, bif.rsp_valid, busy} !== 5'b00001) begin failed++; $display("FAIL rd_wait1: got %b exp 00001", {bif.bus_r_en, bif.rsp_valid, busy}); end
        tick();
        tests_run++; if (bif.rsp_valid !== 3'b000) begin failed++; $display("FAIL rd_wait2: got %b exp 000", bif.rsp_valid); end
        tick();
        tests_run++; if (bif.rsp_valid !== 3'b010) begin failed++; $display("FAIL rd_rsp: got %b exp 010", bif.rsp_valid); end
        tests_run++; if (bif.rsp_rdata !== 8'h3C) begin failed++; $display("FAIL rd_rdata: got %h exp 3c", bif.rsp_rdata); end
        tests_run++; if (grant_id !== 2'd1) begin failed++; $display("FAIL rd_grant: got %0d exp 1", grant_id); end
        tick();
        tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL rd_done: got %b exp 0", busy); end
    endtask

    task automatic test_round_robin();
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        tick();
        bif.req_valid = 3'b111; bif.req_write = 3'b111;
        bif.req_addr = {8'h22, 8'h21, 8'h20}; bif.req_wdata = {8'hC2, 8'hC1, 8'hC0};
        for (int k = 0; k < 6; k++) begin
            logic [2:0] exp_oh;
            logic [1:0] exp_id;
            exp_id = 2'(k % 3);
            exp_oh = 3'b001 << exp_id;
            #1;
            tests_run++; if (bif.req_ready !== exp_oh) begin failed++; $display("FAIL rr_ready[%0d]: got %b exp %b", k, bif.req_ready, exp_oh); end
            tick();
            tests_run++; if ({grant_id, bif.bus_addr} !== {exp_id, 8'h20 + 8'(exp_id)}) begin failed++; $display("FAIL rr_grant[%0d]: got %0d/%h exp %0d", k, grant_id, bif.bus_addr, exp_id); end
            tick();
            tests_run++; if (bif.rsp_valid !== exp_oh) begin failed++; $display("FAIL rr_rsp[%0d]: got %b exp %b", k, bif.rsp_valid, exp_oh); end
            tick();
        end
        bif.req_valid = '0;
    endtask

    task automatic test_sleep();
        tick();
        bif.req_valid = 3'b100; bif.req_write = 3'b100;
        bif.req_addr = {8'h30, 8'h21, 8'h20}; bif.req_wdata = {8'hC3, 8'hC1, 8'hC0};
        #1;
        tests_run++; if (bif.req_ready !== 3'b100) begin failed++; $display("FAIL slp_ready: got %b exp 100", bif.req_ready); end
        tick();
        sleep = 1'b1; bif.req_valid = 3'b111; bif.req_write = 3'b111;
        #1;
        tests_run++; if ({bif.bus_w_en, bif.req_ready} !== 4'b1000) begin failed++; $display("FAIL slp_strobe: got %b exp 1000", {bif.bus_w_en, bif.req_ready}); end
        tick();
        tests_run++; if (bif.rsp_valid !== 3'b100) begin failed++; $display("FAIL slp_rsp: got %b exp 100", bif.rsp_valid); end
        for (int c = 0; c < 2; c++) begin
            tick();
            tests_run++; if ({busy, bif.req_ready} !== 4'b0000) begin failed++; $display("FAIL slp_block[%0d]: got %b exp 0000", c, {busy, bif.req_ready}); end
        end
        tick();
        sleep = 1'b0;
        #1;
        tests_run++; if (bif.req_ready !== 3'b001) begin failed++; $display("FAIL slp_resume: got %b exp 001", bif.req_ready); end
        tick();
        bif.req_valid = '0;
        tests_run++; if ({grant_id, bif.bus_w_en} !== 3'b001) begin failed++; $display("FAIL slp_grant: got %b exp 001", {grant_id, bif.bus_w_en}); end
        tick(); tick(); tick();
    endtask

    task automatic test_no_accept();
        tick();
        bif.req_valid = 3'b010; bif.req_write = 3'b010;
        #1;
        tests_run++; if (bif.req_ready !== 3'b010) begin failed++; $display("FAIL na_ready: got %b exp 010", bif.req_ready); end
        bif.req_valid = '0;
        tick();
        tests_run++; if ({busy, bif.bus_w_en} !== 2'b00) begin failed++; $display("FAIL na_idle: got %b exp 00", {busy, bif.bus_w_en}); end
    endtask

    task automatic test_reset_mid();
        tick();
        bif.req_valid = 3'b010; bif.req_write = 3'b000;
        bif.req_addr = {8'h12, 8'h10, 8'h00};
        #1;
        tests_run++; if (bif.req_ready !== 3'b010) begin failed++; $display("FAIL rm_ready: got %b exp 010", bif.req_ready); end
        tick();
        bif.req_valid = '0;
        tests_run++; if (bif.bus_r_en !== 1'b1) begin failed++; $display("FAIL rm_strobe: got %b exp 1", bif.bus_r_en); end
        tick();
        bif.req_valid = 3'b110; bif.req_addr = {8'h12, 8'h11, 8'h00};
        #1 reset_n = 1'b0;
        #1;
        tests_run++; if ({busy, bif.bus_w_en, bif.bus_r_en, bif.rsp_valid} !== 6'h0) begin failed++; $display("FAIL rm_ctrl: got %b exp 0", {busy, bif.bus_w_en, bif.bus_r_en, bif.rsp_valid}); end
        tests_run++; if ({bif.bus_addr, bif.bus_wdata, bif.rsp_rdata, grant_id} !== 26'h0) begin failed++; $display("FAIL rm_data: got %h exp 0", {bif.bus_addr, bif.bus_wdata, bif.rsp_rdata, grant_id}); end
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++; if ({busy, bif.rsp_valid} !== 4'b0000) begin failed++; $display("FAIL rm_norsp[%0d]: got %b exp 0000", c, {busy, bif.rsp_valid}); end
        end
        @(negedge clk) reset_n = 1'b1;
        #1;
        tests_run++; if (bif.req_ready !== 3'b010) begin failed++; $display("FAIL rm_restart: got %b exp 010", bif.req_ready); end
        tick();
        bif.req_valid = '0;
        tests_run++; if ({grant_id, bif.bus_r_en, bif.bus_addr} !== {2'd1, 1'b1, 8'h11}) begin failed++; $display("FAIL rm_grant: got %b exp 0111_0001_0001", {grant_id, bif.bus_r_en, bif.bus_addr}); end
        tick(); tick(); tick();
        tests_run++; if ({bif.rsp_valid, bif.rsp_rdata} !== {3'b010, 8'h4B}) begin failed++; $display("FAIL rm_rsp: got %b/%h exp 010/4b", bif.rsp_valid, bif.rsp_rdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        tick();
        bif.req_valid = 3'b001; bif.req_write = 3'b001;
        bif.req_addr = {8'h00, 8'h00, 8'h40}; bif.req_wdata = {8'h00, 8'h00, 8'h77};
        for (int c = 0; c < 12; c++) begin
            logic [2:0] exp_rdy;
            logic       exp_wen;
            exp_rdy = (c % 3 == 0) ? 3'b001 : 3'b000;
            exp_wen = (c % 3 == 1);
            #1;
            tests_run++; if ({bif.req_ready, bif.bus_w_en} !== {exp_rdy, exp_wen}) begin failed++; $display("FAIL b2b[%0d]: got %b exp %b", c, {bif.req_ready, bif.bus_w_en}, {exp_rdy, exp_wen}); end
            tick();
        end
        bif.req_valid = '0;
        tick(); tick(); tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_sleep();
        test_no_accept();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Round-robin arbiter and sequencer for the shared LED-driver register bus. It multiplexes single-beat register read/write requests from up to `NUM_REQ` masters (slot 0: I2C controller; slot 1: pattern sequencer; slot 2: fault logger) onto one register-bus master port. It issues exactly one bus strobe per accepted request and returns a completion, with read data, to the owning requester. It sits between the requesters and the register file, replacing direct bus drive by any single master.

## Interface
Parameters:
- `NUM_REQ`, 3, number of requesters (2..8)
- `ADDR_BITS`, 8, register address width
- `DATA_BITS`, 8, register data width
- `RD_LATENCY`, 1, cycles from `bus_r_en` high to `bus_rdata` valid (1..4)

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `sleep`  in  1  global sleep; blocks new grants
- `req_valid`  in  NUM_REQ  per-requester request pending
- `req_write`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_BITS  packed addresses; slot i at [i*ADDR_BITS +: ADDR_BITS]
- `req_wdata`  in  NUM_REQ*DATA_BITS  packed write data, same packing
- `req_ready`  out  NUM_REQ  one-hot accept; combinational
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle completion pulse
- `rsp_rdata`  out  DATA_BITS  read data of the most recent read
- `bus_addr`  out  ADDR_BITS  register address
- `bus_wdata`  out  DATA_BITS  register write data
- `bus_w_en`  out  1  one-cycle write strobe
- `bus_r_en`  out  1  one-cycle read strobe
- `bus_rdata`  in  DATA_BITS  register read data
- `busy`  out  1  high in any state other than ARB_IDLE
- `grant_id`  out  $clog2(NUM_REQ)  index of the current/last granted requester

## Operation
- FSM states:
  - ARB_IDLE -> ARB_ISSUE on accept.
  - ARB_ISSUE -> ARB_RESP for a write.
  - ARB_ISSUE -> ARB_WAIT for a read.
  - ARB_WAIT -> ARB_RESP after RD_LATENCY cycles.
  - ARB_RESP -> ARB_IDLE.
  - Illegal encodings -> ARB_IDLE.
- Arbitration happens only in ARB_IDLE with `sleep`=0. The winner is the first asserted `req_valid` searching from `last_ptr+1` upward, wrapping modulo NUM_REQ.
- `req_ready[i]` = (state==ARB_IDLE) & !sleep & winner==i & `req_valid[i]`. At most one bit is ever set.
- Accept (valid & ready) latches addr, wdata, write, and index. It also updates `last_ptr` and `grant_id` to the winner.
- ARB_ISSUE:
  - `bus_addr`/`bus_wdata` are already driven from the latches (registered at accept).
  - Exactly one of `bus_w_en`/`bus_r_en` is high for exactly one cycle.
- ARB_WAIT:
  - Down-counter loaded with RD_LATENCY-1.
  - On the cycle the count reaches 0, `bus_rdata` is captured into `rsp_rdata`.
- ARB_RESP: `rsp_valid[idx]` pulses high for one cycle.
- `rsp_rdata` changes only on read capture. Writes leave it unchanged.
- `bus_addr`/`bus_wdata` hold their last values between transactions.
- `sleep` behaviour:
  - Asserting `sleep` prevents new accepts only.
  - An in-flight transaction completes normally, including its strobe and response.
- Requests not granted stay pending. The arbiter never drops or reorders a requester's own requests.
- Requesters must hold `req_*` stable while `req_valid` is high and ready is low.

## Timing
- Write accepted in cycle T:
  - `bus_w_en` is high in T+1.
  - `rsp_valid` is high in T+2.
  - The next accept can occur at T+3.
- Read accepted in cycle T:
  - `bus_r_en` is high in T+1.
  - `bus_rdata` is sampled in T+1+RD_LATENCY.
  - `rsp_valid` is high and `rsp_rdata` is valid in T+2+RD_LATENCY.
- Throughput: one write per 3 cycles; one read per 3+RD_LATENCY cycles.
- Reset values, all applied asynchronously on `reset_n`=0:
  - state = ARB_IDLE.
  - `last_ptr` = NUM_REQ-1, so slot 0 has first priority.
  - `grant_id`=0.
  - All strobes, `rsp_valid`, `req_ready`, `busy`, `bus_addr`, `bus_wdata`, `rsp_rdata` = 0.
- Reset mid-transaction:
  - Strobes and `busy` drop immediately.
  - No `rsp_valid` is issued for the aborted request.
  - After release, arbitration restarts from slot 0.
- `req_valid` deasserted in the same cycle as ready is not an accept; state stays ARB_IDLE.
- A single requester with `req_valid` held high is re-granted every 3 (write) cycles; round-robin does not stall a sole requester.

## Test plan
- Reset then slot 0 writes addr 0x05 data 0xA5 at T -> `bus_w_en`=1, `bus_addr`=0x05, `bus_wdata`=0xA5 at T+1; `rsp_valid`=3'b001 at T+2; `rsp_rdata` unchanged (0x00).
- RD_LATENCY=2, slot 1 reads addr 0x10, model returns 0x3C -> `bus_r_en` at T+1; `rsp_valid`=3'b010 and `rsp_rdata`=0x3C at T+4.
- All three slots request continuously from reset -> grant order 0,1,2,0,1,2; each `rsp_valid` bit matches `grant_id` of its accept.
- Assert `sleep` during slot 2's ARB_ISSUE write -> write strobe and response still occur; no further `req_ready` while `sleep`=1; grant resumes at slot 0 the cycle after `sleep` drops.
- Drive `reset_n` low during ARB_WAIT of a read -> strobes, `busy`, outputs clear asynchronously; no `rsp_valid`; first post-reset grant goes to the lowest pending slot.
- Slot 0 only, back-to-back writes with `req_valid` held -> accepts spaced exactly 3 cycles, `bus_w_en` never high on consecutive cycles.
